// File: rtl/mul_pkg.sv
// ---------------------------------------------------------------------------
// mul_pkg
//   Shared definitions for the sequential shift-add multiplier.
//   - state_t : FSM state encoding (IDLE, BUSY, DONE)
//   - clog2   : ceiling log2, used to size the step counter
//   No ports; imported by mul_sign_mag and mul_seq_shift_add.
// ---------------------------------------------------------------------------
package mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Ceiling log2 evaluated at elaboration time; clog2(1) returns 0.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mul_sign_mag.sv
// ---------------------------------------------------------------------------
// mul_sign_mag
//   Combinational sign/magnitude helper.
//   Extracts the sign of x when is_signed is set and produces y, which is x
//   negated (two's complement, modulo 2^W) whenever the extracted sign and
//   neg_req disagree. With neg_req=0 this yields |x|; with is_signed=0 it is
//   a plain conditional negate driven by neg_req.
//   Ports:
//     x         in   W   operand
//     is_signed in   1   treat x as two's complement
//     neg_req   in   1   additionally request a negation
//     y         out  W   conditionally negated x
//     sign      out  1   is_signed & x[W-1]
// ---------------------------------------------------------------------------
module mul_sign_mag
    import mul_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic         is_signed,
    input  logic         neg_req,
    output logic [W-1:0] y,
    output logic         sign
);

    assign sign = is_signed & x[W-1];

    // The most negative value maps onto itself bit-wise, which read as an
    // unsigned W-bit number is exactly its magnitude, so no extra bit is
    // needed on the magnitude path.
    always_comb begin
        y = x;
        if (sign ^ neg_req) begin
            y = ~x + W'(1);
        end
    end

endmodule

// File: rtl/mul_seq_shift_add.sv
// ---------------------------------------------------------------------------
// mul_seq_shift_add
//   Iterative shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, with a
//   per-operation signed/unsigned mode and valid/ready handshakes on both
//   sides. One operation in flight: IDLE -> BUSY -> DONE -> IDLE.
//   Ports:
//     clk, rst   clock and synchronous active-high reset
//     in_valid   in   operands a, b, sign_mode valid
//     in_ready   out  high only in IDLE
//     a, b       in   WIDTH-bit multiplicand / multiplier
//     sign_mode  in   0 unsigned, 1 two's complement
//     out_valid  out  z holds a finished product (DONE)
//     out_ready  in   consumer accepts z
//     z          out  2*WIDTH-bit product
//     busy       out  high in BUSY and DONE
//   Build option:
//     MUL_EARLY_TERM_EN - leave BUSY as soon as the remaining multiplier
//     bits are all zero; product unchanged, latency becomes data dependent.
// ---------------------------------------------------------------------------
module mul_seq_shift_add
    import mul_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               sign_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] z,
    output logic               busy
);

    localparam int CNT_W = clog2(WIDTH + 1);
    localparam int PW    = 2 * WIDTH;

    state_t           state;
    state_t           state_next;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    mcand;
    logic [PW-1:0]    acc_step;
    logic [PW-1:0]    z_final;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [CNT_W-1:0] cnt;
    logic             neg;
    logic             a_sign;
    logic             b_sign;
    logic             last_step;
    logic             res_sign_unused;

    // Operand magnitudes: the multiply core only ever sees unsigned values.
    mul_sign_mag #(.W(WIDTH)) u_mag_a (
        .x         (a),
        .is_signed (sign_mode),
        .neg_req   (1'b0),
        .y         (a_mag),
        .sign      (a_sign)
    );

    mul_sign_mag #(.W(WIDTH)) u_mag_b (
        .x         (b),
        .is_signed (sign_mode),
        .neg_req   (1'b0),
        .y         (b_mag),
        .sign      (b_sign)
    );

    // Final result: restore the sign on the last accumulator value.
    mul_sign_mag #(.W(PW)) u_neg_z (
        .x         (acc_step),
        .is_signed (1'b0),
        .neg_req   (neg),
        .y         (z_final),
        .sign      (res_sign_unused)
    );

    assign in_ready  = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign out_valid = (state == ST_DONE);

    // One shift-add step; the sum always fits because the final product of
    // two WIDTH-bit magnitudes fits in 2*WIDTH bits.
    assign acc_step = mplier[0] ? (acc + mcand) : acc;

    // Decide whether the current BUSY cycle is the last one. In the early
    // terminating build the counter remains as a backstop; by the final
    // step the post-shift multiplier is zero anyway, so it never changes
    // the outcome.
    always_comb begin
`ifdef MUL_EARLY_TERM_EN
        last_step = (mplier[WIDTH-1:1] == '0) || (cnt == CNT_W'(WIDTH - 1));
`else
        last_step = (cnt == CNT_W'(WIDTH - 1));
`endif
    end

    // State register; reset takes priority over every other event.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept in IDLE, iterate in BUSY, wait for the
    // consumer in DONE.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (in_valid)  state_next = ST_BUSY;
            ST_BUSY: if (last_step) state_next = ST_DONE;
            ST_DONE: if (out_ready) state_next = ST_IDLE;
            default:                state_next = ST_IDLE;
        endcase
    end

    // Datapath: capture operands on accept, then shift and add once per
    // BUSY cycle, loading z on the exit edge. z is left untouched in DONE
    // and IDLE so it stays stable under backpressure and after transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            z      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        neg    <= a_sign ^ b_sign;
                        mcand  <= {{WIDTH{1'b0}}, a_mag};
                        mplier <= b_mag;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                ST_BUSY: begin
                    acc    <= acc_step;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_step) begin
                        z <= z_final;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
